// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and types for the multi-port register file.
package grf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Register address at the default geometry.
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // Write trace line format; matches the golden-model log.
  localparam string TRACE_FMT = "%d@%h: $%d <= %h";

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register write-pending bits for the hazard unit.
// A write clears its register's bit, an alloc sets it (alloc wins over a
// same-cycle write), and flush or reset clears everything.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        pend_rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_next;

  // Next pending vector: clear written registers, then set the new producer.
  always_comb begin
    // NOTE: default-assign first so every path drives pend_next and no latch is inferred.
    pend_next = pend;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j]) pend_next[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (alloc_en && (alloc_addr != '0)) pend_next[alloc_addr] = 1'b1;
  end

  // Pending register: reset and flush both clear, flush overrides alloc.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample together.
    if (reset)      pend <= '0;
    else if (flush) pend <= '0;
    else            pend <= pend_next;
  end

  // Pending-bit lookup for each read port.
  always_comb begin
    pend_rd = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      pend_rd[i] = pend[raddr[i*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/grf_mp.sv
// grf_mp: multi-port general register file with same-cycle write bypass and
// a write-pending scoreboard. Register 0 is hard zero and never pending.
// Optional feature macro: GRF_TRACE_EN prints one trace line per active write.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rready,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_WR*32-1:0]     wpc,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic                     flush
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [NUM_RD-1:0] pend_rd;

  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .raddr      (raddr),
    .pend_rd    (pend_rd)
  );

  // Register array write; later (younger) ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array must read zero after reset, so it is built from resettable flops, not RAM.
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (waddr[j*ADDR_W +: ADDR_W] != '0))
          regs[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // Read ports: array value, overridden by the youngest matching write;
  // any matching write also makes the value final.
  always_comb begin
    rdata  = '0;
    rready = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdata[i*DATA_W +: DATA_W] = regs[raddr[i*ADDR_W +: ADDR_W]];
      rready[i] = ~pend_rd[i];
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])) begin
          rready[i] = 1'b1;
          if (raddr[i*ADDR_W +: ADDR_W] != '0)
            rdata[i*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef GRF_TRACE_EN
  // Write trace, port order ascending, including writes to register 0.
  always @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j])
          $display(TRACE_FMT, $time, wpc[j*32 +: 32],
                   waddr[j*ADDR_W +: ADDR_W], wdata[j*DATA_W +: DATA_W]);
      end
    end
  end
`else
  // The PC inputs only feed the trace.
  logic wpc_unused;
  assign wpc_unused = ^wpc;
`endif

endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: directed test-plan sequence plus randomized traffic, checked
// every cycle against a behavioural register-file model.
module tb_grf_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rready;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_WR*32-1:0]     wpc;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state.
  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_pend [DEPTH];

  grf_mp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raddr      (raddr),
    .rdata      (rdata),
    .rready     (rready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .wpc        (wpc),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update on each edge, straight from the register-file rules.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_regs[k] = '0;
        m_pend[k] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        int a;
        a = int'(waddr[j*ADDR_W +: ADDR_W]);
        if (we[j] && a != 0) m_regs[a] = wdata[j*DATA_W +: DATA_W];
      end
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) m_pend[k] = 1'b0;
      end else begin
        for (int j = 0; j < NUM_WR; j++)
          if (we[j]) m_pend[int'(waddr[j*ADDR_W +: ADDR_W])] = 1'b0;
        if (alloc_en && alloc_addr != 0) m_pend[int'(alloc_addr)] = 1'b1;
      end
    end
  end

  // Compare process: every cycle, outputs against the model's prediction.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NUM_RD; i++) begin
        int ra;
        logic [DATA_W-1:0] exp_d;
        bit exp_r;
        bit hit;
        ra    = int'(raddr[i*ADDR_W +: ADDR_W]);
        exp_d = (ra == 0) ? '0 : m_regs[ra];
        hit   = 1'b0;
        for (int j = NUM_WR - 1; j >= 0; j--) begin
          if (!hit && we[j] && int'(waddr[j*ADDR_W +: ADDR_W]) == ra) begin
            hit = 1'b1;
            if (ra != 0) exp_d = wdata[j*DATA_W +: DATA_W];
          end
        end
        exp_r = hit || !m_pend[ra];
        check($sformatf("model_rdata%0d", i), rdata[i*DATA_W +: DATA_W], exp_d);
        check($sformatf("model_rready%0d", i), {31'b0, rready[i]}, {31'b0, exp_r});
      end
    end
  end

  task automatic idle();
    reset    = 1'b0;
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    flush    = 1'b0;
  endtask

  // Advance to the next cycle's input-drive point.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Wait to the sampling point of the current cycle.
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    we[port] = 1'b1;
    waddr[port*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wdata[port*DATA_W +: DATA_W] = d;
    wpc[port*32 +: 32] = 32'h1000 + 32'(a * 4);
  endtask

  task automatic rd(input int port, input int a);
    raddr[port*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  initial begin
    idle();
    wpc   = '0;
    raddr = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle();
    cmp_en = 1'b1;

    // Every address reads zero and ready after reset.
    for (int a = 0; a < DEPTH; a++) begin
      rd(0, a);
      rd(1, DEPTH - 1 - a);
      sample();
      check("rst_rdata0", rdata[0 +: DATA_W], 32'h0);
      check("rst_rdata1", rdata[DATA_W +: DATA_W], 32'h0);
      check("rst_rready", {30'b0, rready}, 32'h3);
      next_cycle();
    end

    // Same-cycle bypass, then stored value.
    wr(0, 5, 32'h1234); rd(0, 5);
    sample(); check("bypass_5", rdata[0 +: DATA_W], 32'h1234);
    next_cycle(); rd(0, 5);
    sample(); check("stored_5", rdata[0 +: DATA_W], 32'h1234);

    // Dual write to one address: port 1 wins.
    next_cycle();
    wr(0, 7, 32'hAAAA); wr(1, 7, 32'hBBBB); rd(0, 7);
    sample(); check("dual_bypass_7", rdata[0 +: DATA_W], 32'hBBBB);
    next_cycle(); rd(0, 7);
    sample(); check("dual_stored_7", rdata[0 +: DATA_W], 32'hBBBB);

    // Alloc, stall, resolve by write.
    next_cycle(); alloc_en = 1'b1; alloc_addr = 5'd9;
    next_cycle(); rd(0, 9);
    sample(); check("alloc_rready", {31'b0, rready[0]}, 32'h0);
    next_cycle(); rd(0, 9); wr(0, 9, 32'h55);
    sample(); check("wr_rready", {31'b0, rready[0]}, 32'h1);
    check("wr_rdata", rdata[0 +: DATA_W], 32'h55);
    next_cycle(); rd(0, 9);
    sample(); check("cleared_rready", {31'b0, rready[0]}, 32'h1);

    // Alloc and write on the same edge keeps pending; flush clears; alloc $0 ignored.
    next_cycle(); rd(0, 9); wr(1, 9, 32'h66); alloc_en = 1'b1; alloc_addr = 5'd9;
    next_cycle(); rd(0, 9);
    sample(); check("alloc_wins", {31'b0, rready[0]}, 32'h0);
    check("alloc_wins_data", rdata[0 +: DATA_W], 32'h66);
    next_cycle(); rd(0, 9); flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd12;
    next_cycle(); rd(0, 9); rd(1, 12);
    sample(); check("flush_rready", {30'b0, rready}, 32'h3);
    next_cycle(); alloc_en = 1'b1; alloc_addr = 5'd0;
    next_cycle(); rd(0, 0);
    sample(); check("alloc0_rready", {31'b0, rready[0]}, 32'h1);

    // Register 0 is never written; reset wipes everything in flight.
    next_cycle(); wr(0, 3, 32'hFFFFFFFF);
    next_cycle(); wr(1, 0, 32'h1); rd(0, 0);
    sample(); check("r0_bypass", rdata[0 +: DATA_W], 32'h0);
    next_cycle(); rd(0, 0); rd(1, 3);
    sample(); check("r0_stored", rdata[0 +: DATA_W], 32'h0);
    check("r3_stored", rdata[DATA_W +: DATA_W], 32'hFFFFFFFF);
    next_cycle(); alloc_en = 1'b1; alloc_addr = 5'd4;
    next_cycle(); reset = 1'b1; wr(0, 3, 32'h77); alloc_en = 1'b1; alloc_addr = 5'd6;
    next_cycle(); rd(0, 3); rd(1, 4);
    sample(); check("rst_r3", rdata[0 +: DATA_W], 32'h0);
    check("rst_pend4", {31'b0, rready[1]}, 32'h1);
    rd(1, 6);
    #1; check("rst_pend6", {31'b0, rready[1]}, 32'h1);

    // Randomized traffic on a narrow address range to force collisions.
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      for (int j = 0; j < NUM_WR; j++) begin
        if ($urandom_range(0, 2) == 0) wr(j, int'($urandom_range(0, 7)), $urandom);
      end
      for (int i = 0; i < NUM_RD; i++) rd(i, int'($urandom_range(0, 7)));
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_addr = ADDR_W'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 99) == 0);
    end

    next_cycle();
    sample();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
